ghost_mode_scheduler: RTL and testbench
=======================================

# ghost_mode_scheduler

Global scatter/chase/frightened sequencer for the ghost AI modules. It divides the 25 MHz clock into a 60 Hz frame tick and steps through the level's fixed scatter/chase phase schedule. It also overrides the schedule with a frightened window whenever Pac-Man eats a power pellet. Its mode outputs drive the `isChase`/`isScatter` inputs of every ghost, and its one-cycle reverse strobe tells the ghosts to turn around.

## Interface
- `TICK_DIV`, default 416_666: clk cycles per frame tick; 25 MHz gives about 60 Hz.
- `SCAT_LONG`, default 420: frames in scatter phases 0 and 2.
- `SCAT_SHORT`, default 300: frames in scatter phases 4 and 6.
- `CHASE_LEN`, default 1200: frames in chase phases 1, 3 and 5.
- `FRIGHT_TICKS`, default 360: frames in a frightened window.
- `FLASH_TICKS`, default 120: final frames of a frightened window during which flashing is active.
- `clk` in 1: system clock, 25 MHz.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: level: game running. Low forces IDLE.
- `pause` in 1: level: freezes the divider and all timers. State and outputs hold.
- `levelRestart` in 1: one-cycle pulse. Returns the block to phase 0 scatter.
- `powerPellet` in 1: one-cycle pulse. Starts or extends the frightened window.
- `isScatter` out 1: underlying phase is scatter and the block is not frightened.
- `isChase` out 1: underlying phase is chase and the block is not frightened.
- `isFrightened` out 1: frightened window is active.
- `frightFlash` out 1: blink indicator for the frightened sprite.
- `reversePulse` out 1: one clk high on each ghost-reversal event.
- `phase` out 3: current schedule index, 0..7.
- `frameTick` out 1: one clk high per frame.

## Operation
- States: IDLE, SCATTER, CHASE, FRIGHT.
- Reset drives the state to IDLE and every output to 0. All counters clear.
- IDLE moves to SCATTER with `phase`=0 on the first clk where `start`=1.
- `start`=0 in any state returns the block to IDLE. All counters and `phase` clear, and no `reversePulse` is issued.
- Divider: counts only while in a non-IDLE state and `pause`=0. When the count reaches `TICK_DIV`-1 it wraps to 0 and asserts `frameTick` for that clk.
- Phase timer: counts up once per `frameTick` while in SCATTER or CHASE. It is frozen in FRIGHT.
- Phase durations: phase 0 is `SCAT_LONG`, phase 2 is `SCAT_LONG`, phases 1, 3 and 5 are `CHASE_LEN`, phases 4 and 6 are `SCAT_SHORT`.
- Phase 7 is chase with no time limit; its timer never expires.
- Phase expiry: on a `frameTick` where the timer equals the phase duration - 1, the timer clears, `phase` increments, and the state toggles between SCATTER and CHASE. `reversePulse`=1 on that clk.
- `powerPellet` in SCATTER or CHASE: enter FRIGHT, load the fright counter with `FRIGHT_TICKS`, `reversePulse`=1. The phase timer value is retained.
- `powerPellet` in FRIGHT: reload the fright counter with `FRIGHT_TICKS`. No `reversePulse`.
- FRIGHT exit: when the fright counter reaches 1 on a `frameTick`, return to SCATTER or CHASE according to `phase`. The phase timer resumes from its retained value. No `reversePulse`.
- `powerPellet` in IDLE is ignored.
- `levelRestart` in a non-IDLE state: the fright counter and phase timer clear, `phase`=0, and the state becomes SCATTER. `reversePulse` stays 0.
- Priority on the same clk: `start`=0 first, then `levelRestart`, then `powerPellet`, then phase or fright expiry. When a pellet coincides with phase expiry, the expiry is discarded and the timer holds at duration-1, so the phase expires on the first frame after FRIGHT exits.
- `pause`=1 suppresses `frameTick` only. `powerPellet` and `levelRestart` are still accepted while paused.
- Width rules: the divider is 20 bits and the phase timer 11 bits. The fright counter is 10 bits and non-zero only while in FRIGHT. `phase` saturates at 7.

## Timing
- All outputs are registered. They update on the clk edge that samples the causing input, so they are visible one cycle after a pulse input is presented.
- `reversePulse` and `frameTick` are exactly one clk wide and never stretched.
- First `frameTick` arrives `TICK_DIV` cycles after the IDLE to SCATTER transition.
- `isScatter`, `isChase` and `isFrightened` are mutually exclusive, and all are 0 in IDLE.

## Configuration
- Macro `GHOST_FRIGHT_FLASH_EN`.
- When defined, `frightFlash` toggles every 15 frames while in FRIGHT and the fright counter is ≤ `FLASH_TICKS`. It starts high on the first such frame.
- When defined, `frightFlash` is 0 outside that window.
- When undefined, `frightFlash` is constant 0 and the flash logic is not synthesized.

## Test plan
All scenarios use `TICK_DIV`=4, `SCAT_LONG`=6, `SCAT_SHORT`=4, `CHASE_LEN`=8, `FRIGHT_TICKS`=5, `FLASH_TICKS`=2.
- Reset, then `start`=1 for 400 cycles -> `phase` steps 0..7 at frames 6, 14, 20, 28, 32, 40, 44. There are exactly 7 `reversePulse`s, and `isChase` holds at `phase`=7.
- `powerPellet` at frame 3 of phase 0 -> `isFrightened` for 5 frames with one `reversePulse`. `isScatter` then returns, and phase 0 ends 3 frames later.
- Second `powerPellet` 2 frames into FRIGHT -> FRIGHT lasts 7 frames total, with a single `reversePulse`.
- `powerPellet` coinciding with phase 0 expiry -> FRIGHT is entered and `phase` stays 0. After FRIGHT, `phase`=1 arrives one frame later.
- `pause` held for 20 cycles mid-chase -> no `frameTick`, and all outputs hold. The schedule resumes with the timer unchanged.
- `levelRestart` during FRIGHT at `phase`=3 -> next cycle `phase`=0, `isScatter`=1, `isFrightened`=0, `reversePulse`=0. `start`=0 -> all outputs 0.

Source files
------------

// File: rtl/ghost_mode_scheduler_if.sv
// Control and mode bus between the game logic and the ghost mode scheduler.
// master: game/top level (drives the control inputs, observes modes).
// slave : the scheduler itself.
// start and pause are levels. levelRestart and powerPellet are one-clk pulses.
// reversePulse and frameTick are one-clk strobes.
interface ghost_mode_scheduler_if;
  logic       start;
  logic       pause;
  logic       levelRestart;
  logic       powerPellet;
  logic       isScatter;
  logic       isChase;
  logic       isFrightened;
  logic       frightFlash;
  logic       reversePulse;
  logic       frameTick;
  logic [2:0] phase;

  modport master (
    output start, pause, levelRestart, powerPellet,
    input  isScatter, isChase, isFrightened, frightFlash, reversePulse, frameTick, phase
  );

  modport slave (
    input  start, pause, levelRestart, powerPellet,
    output isScatter, isChase, isFrightened, frightFlash, reversePulse, frameTick, phase
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// ghost_mode_scheduler: global scatter/chase/frightened sequencer for the ghosts.
// Divides clk into a frame tick, walks the fixed 8-entry scatter/chase schedule,
// and overlays a frightened window on power pellets.
// Optional feature macro: GHOST_FRIGHT_FLASH_EN enables the frightFlash blink logic.
// state_dbg exposes the FSM state (0 IDLE, 1 SCATTER, 2 CHASE, 3 FRIGHT).
module ghost_mode_scheduler #(
  parameter int TICK_DIV     = 416_666,
  parameter int SCAT_LONG    = 420,
  parameter int SCAT_SHORT   = 300,
  parameter int CHASE_LEN    = 1200,
  parameter int FRIGHT_TICKS = 360,
  parameter int FLASH_TICKS  = 120
) (
  input  logic                 clk,
  input  logic                 reset,
  ghost_mode_scheduler_if.slave bus,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    CHASE   = 2'd2,
    FRIGHT  = 2'd3
  } state_e;

  localparam logic [19:0] DIV_MAX       = 20'(TICK_DIV - 1);
  localparam logic [10:0] SCAT_LONG_M1  = 11'(SCAT_LONG - 1);
  localparam logic [10:0] SCAT_SHORT_M1 = 11'(SCAT_SHORT - 1);
  localparam logic [10:0] CHASE_LEN_M1  = 11'(CHASE_LEN - 1);
  localparam logic [9:0]  FRIGHT_LOAD   = 10'(FRIGHT_TICKS);

  state_e      state_q, state_d;
  logic [19:0] div_q, div_d;
  logic [10:0] timer_q, timer_d;
  logic [9:0]  fright_q, fright_d;
  logic [2:0]  phase_q, phase_d;
  logic        is_scatter_q, is_scatter_d;
  logic        is_chase_q, is_chase_d;
  logic        is_fright_q, is_fright_d;
  logic        frame_tick_q, frame_tick_d;
  logic        reverse_q, reverse_d;

  // Last timer value of a timed phase; phase 7 never reaches its expiry check.
  function automatic logic [10:0] phase_last(input logic [2:0] p);
    case (p)
      3'd0, 3'd2: return SCAT_LONG_M1;
      3'd4, 3'd6: return SCAT_SHORT_M1;
      default:    return CHASE_LEN_M1;
    endcase
  endfunction

  // Odd phases are chase, even phases are scatter.
  function automatic state_e phase_mode(input logic [2:0] p);
    return p[0] ? CHASE : SCATTER;
  endfunction

  // Next-state: start=0 beats levelRestart beats powerPellet beats expiry.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    timer_d      = timer_q;
    fright_d     = fright_q;
    phase_d      = phase_q;
    frame_tick_d = 1'b0;
    reverse_d    = 1'b0;

    if (!bus.start) begin
      state_d  = IDLE;
      div_d    = '0;
      timer_d  = '0;
      fright_d = '0;
      phase_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = SCATTER;
    end else begin
      if (!bus.pause) begin
        if (div_q == DIV_MAX) begin
          div_d        = '0;
          frame_tick_d = 1'b1;
        end else begin
          div_d = div_q + 20'd1;
        end
      end

      if (bus.levelRestart) begin
        state_d  = SCATTER;
        timer_d  = '0;
        fright_d = '0;
        phase_d  = '0;
      end else if (bus.powerPellet) begin
        // A pellet on an expiry frame swallows that frame: the timer stays at
        // duration-1 so the phase expires on the first frame after FRIGHT.
        state_d   = FRIGHT;
        fright_d  = FRIGHT_LOAD;
        reverse_d = (state_q != FRIGHT);
      end else if (frame_tick_d) begin
        if (state_q == FRIGHT) begin
          if (fright_q <= 10'd1) begin
            fright_d = '0;
            state_d  = phase_mode(phase_q);
          end else begin
            fright_d = fright_q - 10'd1;
          end
        end else if (phase_q != 3'd7 && timer_q == phase_last(phase_q)) begin
          timer_d   = '0;
          phase_d   = phase_q + 3'd1;
          state_d   = phase_mode(phase_q + 3'd1);
          reverse_d = 1'b1;
        end else if (timer_q != '1) begin
          // Phase 7 runs forever; saturate rather than wrap.
          timer_d = timer_q + 11'd1;
        end
      end
    end

    is_scatter_d = (state_d == SCATTER);
    is_chase_d   = (state_d == CHASE);
    is_fright_d  = (state_d == FRIGHT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= '0;
      timer_q      <= '0;
      fright_q     <= '0;
      phase_q      <= '0;
      is_scatter_q <= 1'b0;
      is_chase_q   <= 1'b0;
      is_fright_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      reverse_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      timer_q      <= timer_d;
      fright_q     <= fright_d;
      phase_q      <= phase_d;
      is_scatter_q <= is_scatter_d;
      is_chase_q   <= is_chase_d;
      is_fright_q  <= is_fright_d;
      frame_tick_q <= frame_tick_d;
      reverse_q    <= reverse_d;
    end
  end

  assign bus.isScatter    = is_scatter_q;
  assign bus.isChase      = is_chase_q;
  assign bus.isFrightened = is_fright_q;
  assign bus.reversePulse = reverse_q;
  assign bus.frameTick    = frame_tick_q;
  assign bus.phase        = phase_q;
  assign state_dbg        = state_q;

`ifdef GHOST_FRIGHT_FLASH_EN
  localparam logic [9:0] FLASH_LVL = 10'(FLASH_TICKS);

  logic       flash_q, flash_d;
  logic       flash_win_q, flash_win_d;
  logic [3:0] flash_cnt_q, flash_cnt_d;

  // Blink: high on entering the final window, then toggle every 15 frames.
  always_comb begin
    flash_d     = 1'b0;
    flash_cnt_d = '0;
    flash_win_d = (state_d == FRIGHT) && (fright_d != '0) && (fright_d <= FLASH_LVL);
    if (flash_win_d) begin
      if (!flash_win_q) begin
        flash_d = 1'b1;
      end else begin
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        if (frame_tick_d) begin
          if (flash_cnt_q == 4'd14) begin
            flash_cnt_d = '0;
            flash_d     = !flash_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 4'd1;
          end
        end
      end
    end
  end

  // Blink registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_q     <= 1'b0;
      flash_win_q <= 1'b0;
      flash_cnt_q <= '0;
    end else begin
      flash_q     <= flash_d;
      flash_win_q <= flash_win_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign bus.frightFlash = flash_q;
`else
  logic unused_flash_cfg;
  assign unused_flash_cfg = ^FLASH_TICKS;
  assign bus.frightFlash  = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler with a small schedule
// (TICK_DIV=4, SCAT_LONG=6, SCAT_SHORT=4, CHASE_LEN=8, FRIGHT_TICKS=5, FLASH_TICKS=2).
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_ghost_mode_scheduler;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         errors;
  int         checks;
  int         rev_cnt;
  int         wide_cnt;
  int         rev_base;
  logic       prev_rev;
  logic       prev_tick;

  ghost_mode_scheduler_if bus ();

  ghost_mode_scheduler #(
    .TICK_DIV    (4),
    .SCAT_LONG   (6),
    .SCAT_SHORT  (4),
    .CHASE_LEN   (8),
    .FRIGHT_TICKS(5),
    .FLASH_TICKS (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // Clock: 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe monitor: counts reverse pulses and any strobe held two clks.
  initial begin
    rev_cnt   = 0;
    wide_cnt  = 0;
    prev_rev  = 1'b0;
    prev_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.reversePulse) rev_cnt++;
      if ((bus.reversePulse && prev_rev) || (bus.frameTick && prev_tick)) wide_cnt++;
      prev_rev  = bus.reversePulse;
      prev_tick = bus.frameTick;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the falling edge right after the next frame tick (bounded).
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frameTick !== 1'b1 && n < 12);
    checks++;
    assert (bus.frameTick === 1'b1) else begin
      errors++;
      $error("FAIL tick_timeout: observed %0b expected 1", bus.frameTick);
    end
  endtask

  task automatic pellet();
    bus.powerPellet = 1'b1;
    @(negedge clk);
    bus.powerPellet = 1'b0;
  endtask

  task automatic restart_pulse();
    bus.levelRestart = 1'b1;
    @(negedge clk);
    bus.levelRestart = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_scat"},  bus.isScatter,    1'b0);
    chk({tag, "_chase"}, bus.isChase,      1'b0);
    chk({tag, "_frt"},   bus.isFrightened, 1'b0);
    chk({tag, "_phase"}, bus.phase,        3'd0);
    chk({tag, "_rev"},   bus.reversePulse, 1'b0);
    chk({tag, "_tick"},  bus.frameTick,    1'b0);
    chk({tag, "_flash"}, bus.frightFlash,  1'b0);
  endtask

  // Re-enter SCATTER phase 0 with all counters cleared.
  task automatic fresh_start();
    bus.start = 1'b0;
    cyc(1);
    chk_idle("stop");
    bus.start = 1'b1;
    cyc(1);
    chk("fresh_scat", bus.isScatter, 1'b1);
  endtask

  initial begin
    int bnd[7];
    int exp_phase;
    bit is_bnd;
    bnd = '{6, 14, 20, 28, 32, 40, 44};
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.levelRestart = 1'b0;
    bus.powerPellet = 1'b0;

    // Reset state.
    cyc(3);
    chk_idle("reset");
    chk("reset_state", state_dbg, 2'd0);
    reset = 1'b0;
    cyc(1);
    chk_idle("idle");

    // Pellet in IDLE is ignored.
    pellet();
    chk("idle_pellet_frt", bus.isFrightened, 1'b0);
    chk("idle_pellet_rev", bus.reversePulse, 1'b0);

    // Full schedule: phase steps at frames 6,14,20,28,32,40,44.
    rev_base = rev_cnt;
    bus.start = 1'b1;
    cyc(1);
    chk("s1_scat", bus.isScatter, 1'b1);
    chk("s1_phase", bus.phase, 3'd0);
    chk("s1_state", state_dbg, 2'd1);
    cyc(3);
    chk("s1_no_tick_yet", bus.frameTick, 1'b0);
    cyc(1);
    chk("s1_first_tick", bus.frameTick, 1'b1);
    for (int f = 2; f <= 44; f++) begin
      wait_tick();
      exp_phase = 0;
      is_bnd = 1'b0;
      for (int b = 0; b < 7; b++) begin
        if (f >= bnd[b]) exp_phase++;
        if (f == bnd[b]) is_bnd = 1'b1;
      end
      chk("s1_phase_f", bus.phase, 32'(exp_phase));
      chk("s1_rev_f", bus.reversePulse, {31'd0, is_bnd});
      chk("s1_chase_f", bus.isChase, 32'(exp_phase % 2));
    end
    cyc(223);
    chk("s1_rev_total", rev_cnt - rev_base, 7);
    chk("s1_phase7", bus.phase, 3'd7);
    chk("s1_chase7", bus.isChase, 1'b1);
    chk("s1_scat7", bus.isScatter, 1'b0);

    // Pellet at frame 3 of phase 0.
    fresh_start();
    rev_base = rev_cnt;
    repeat (3) wait_tick();
    cyc(1);
    pellet();
    chk("s2_frt", bus.isFrightened, 1'b1);
    chk("s2_scat", bus.isScatter, 1'b0);
    chk("s2_rev", bus.reversePulse, 1'b1);
    chk("s2_state", state_dbg, 2'd3);
    chk("s2_flash", bus.frightFlash, 1'b0);
    cyc(1);
    chk("s2_rev_narrow", bus.reversePulse, 1'b0);
    repeat (4) wait_tick();
    chk("s2_still_frt", bus.isFrightened, 1'b1);
    wait_tick();
    chk("s2_exit_frt", bus.isFrightened, 1'b0);
    chk("s2_exit_scat", bus.isScatter, 1'b1);
    chk("s2_exit_rev", bus.reversePulse, 1'b0);
    repeat (2) wait_tick();
    chk("s2_phase_hold", bus.phase, 3'd0);
    wait_tick();
    chk("s2_phase1", bus.phase, 3'd1);
    chk("s2_chase", bus.isChase, 1'b1);
    chk("s2_rev_total", rev_cnt - rev_base, 2);

    // Second pellet two frames into FRIGHT: seven frightened frames.
    fresh_start();
    rev_base = rev_cnt;
    wait_tick();
    cyc(1);
    pellet();
    repeat (2) wait_tick();
    cyc(1);
    pellet();
    chk("s3_reload_rev", bus.reversePulse, 1'b0);
    chk("s3_reload_frt", bus.isFrightened, 1'b1);
    repeat (4) wait_tick();
    chk("s3_still_frt", bus.isFrightened, 1'b1);
    wait_tick();
    chk("s3_exit_scat", bus.isScatter, 1'b1);
    chk("s3_phase", bus.phase, 3'd0);
    chk("s3_rev_total", rev_cnt - rev_base, 1);

    // Pellet on the phase 0 expiry frame.
    fresh_start();
    repeat (5) wait_tick();
    cyc(3);
    pellet();
    chk("s4_tick_coincide", bus.frameTick, 1'b1);
    chk("s4_frt", bus.isFrightened, 1'b1);
    chk("s4_phase0", bus.phase, 3'd0);
    chk("s4_rev", bus.reversePulse, 1'b1);
    repeat (5) wait_tick();
    chk("s4_exit_scat", bus.isScatter, 1'b1);
    chk("s4_exit_phase", bus.phase, 3'd0);
    wait_tick();
    chk("s4_phase1", bus.phase, 3'd1);
    chk("s4_chase", bus.isChase, 1'b1);
    chk("s4_rev1", bus.reversePulse, 1'b1);

    // Pause for 20 cycles in chase (phase 1, timer 2).
    repeat (2) wait_tick();
    cyc(1);
    bus.pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("s5_pause_tick", bus.frameTick, 1'b0);
      chk("s5_pause_chase", bus.isChase, 1'b1);
      chk("s5_pause_phase", bus.phase, 3'd1);
    end
    bus.pause = 1'b0;
    cyc(2);
    chk("s5_resume_no_tick", bus.frameTick, 1'b0);
    cyc(1);
    chk("s5_resume_tick", bus.frameTick, 1'b1);
    repeat (4) wait_tick();
    chk("s5_phase1_hold", bus.phase, 3'd1);
    wait_tick();
    chk("s5_phase2", bus.phase, 3'd2);
    chk("s5_scat", bus.isScatter, 1'b1);

    // levelRestart during FRIGHT at phase 3.
    repeat (6) wait_tick();
    chk("s6_phase3", bus.phase, 3'd3);
    cyc(1);
    pellet();
    chk("s6_frt", bus.isFrightened, 1'b1);
    cyc(2);
    restart_pulse();
    chk("s6_phase0", bus.phase, 3'd0);
    chk("s6_scat", bus.isScatter, 1'b1);
    chk("s6_frt0", bus.isFrightened, 1'b0);
    chk("s6_chase0", bus.isChase, 1'b0);
    chk("s6_rev0", bus.reversePulse, 1'b0);
    repeat (5) wait_tick();
    chk("s6_timer_cleared", bus.phase, 3'd0);
    wait_tick();
    chk("s6_phase1", bus.phase, 3'd1);
    bus.start = 1'b0;
    cyc(1);
    chk_idle("s6_stop");
    chk("s6_stop_state", state_dbg, 2'd0);

    // Asynchronous reset mid-run.
    bus.start = 1'b1;
    cyc(2);
    chk("ar_scat", bus.isScatter, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_scat0", bus.isScatter, 1'b0);
    chk("ar_state", state_dbg, 2'd0);
    cyc(2);
    reset = 1'b0;
    cyc(1);

    chk("strobe_width", wide_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
